// File: rtl/forward_hazard_unit_pkg.sv
// Shared encodings and shadow-entry type for the EX-stage forwarding / hazard unit.
package forward_hazard_unit_pkg;

    localparam int unsigned TAG_W = 6;
    localparam logic [TAG_W-1:0] TAG_X0 = 6'b0_00000;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwdSel_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } fsmState_e;

    typedef struct packed {
        logic             valid;
        logic             regWrite;
        logic             memRead;
        logic [TAG_W-1:0] tag;
    } shadowEntry_t;

    // An entry is a forwarding candidate only if it is live and writes a register.
    function automatic logic canForward(input shadowEntry_t e);
        return e.valid & e.regWrite;
    endfunction

endpackage

// File: rtl/fwd_tag_match.sv
// Compares one ID source tag against the EX and MEM shadow tags and picks the
// forwarding source it will need one cycle later; x0 never matches.
module fwd_tag_match
    import forward_hazard_unit_pkg::*;
(
    input  logic [TAG_W-1:0] srcTag,
    input  logic             srcUsed,
    input  logic             exValid,
    input  logic [TAG_W-1:0] exTag,
    input  logic             memValid,
    input  logic [TAG_W-1:0] memTag,
    output fwdSel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        if (srcUsed && (srcTag != TAG_X0)) begin
            // The EX producer is the newer one, so it wins over MEM.
            if (exValid && (exTag == srcTag)) begin
                sel = FWD_MEM;
            end else if (memValid && (memTag == srcTag)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX operand-forwarding selects plus load-use and multi-cycle FPU stall control,
// driven from a private shadow of the EX/MEM/WB destination tags.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int unsigned FPU_LAT = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_valid,
    input  logic [TAG_W-1:0] ID_rs1,
    input  logic [TAG_W-1:0] ID_rs2,
    input  logic [TAG_W-1:0] ID_rs3,
    input  logic             ID_rs1Used,
    input  logic             ID_rs2Used,
    input  logic             ID_rs3Used,
    input  logic [TAG_W-1:0] ID_rd,
    input  logic             ID_regWrite,
    input  logic             ID_memRead,
    input  logic             ID_multicycle,
    input  logic             flush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [1:0]       forwardC,
    output logic             stallID,
    output logic             bubbleEX,
    output logic             exHold
);

    fsmState_e    stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;

    shadowEntry_t exTagQ, memTagQ, wbTagQ;
    shadowEntry_t idEntry;
    fwdSel_e      selA, selB, selC;
    fwdSel_e      fwdAQ, fwdBQ, fwdCQ;

    logic idLive;
    logic busy;
    logic loadUse;
    logic unusedWb;

    assign idLive = ID_valid & ~flush;
    assign busy   = (stateQ == StBusy);

    always_comb begin
        idEntry = '0;
        if (idLive) begin
            idEntry.valid    = 1'b1;
            idEntry.regWrite = ID_regWrite;
            idEntry.memRead  = ID_memRead;
            idEntry.tag      = ID_rd;
        end
    end

    fwd_tag_match uMatchA (
        .srcTag  (ID_rs1),
        .srcUsed (ID_rs1Used & idLive),
        .exValid (canForward(exTagQ)),
        .exTag   (exTagQ.tag),
        .memValid(canForward(memTagQ)),
        .memTag  (memTagQ.tag),
        .sel     (selA)
    );

    fwd_tag_match uMatchB (
        .srcTag  (ID_rs2),
        .srcUsed (ID_rs2Used & idLive),
        .exValid (canForward(exTagQ)),
        .exTag   (exTagQ.tag),
        .memValid(canForward(memTagQ)),
        .memTag  (memTagQ.tag),
        .sel     (selB)
    );

    fwd_tag_match uMatchC (
        .srcTag  (ID_rs3),
        .srcUsed (ID_rs3Used & idLive),
        .exValid (canForward(exTagQ)),
        .exTag   (exTagQ.tag),
        .memValid(canForward(memTagQ)),
        .memTag  (memTagQ.tag),
        .sel     (selC)
    );

    // A MEM-select against a load in EX means the data is not ready yet.
    assign loadUse = exTagQ.memRead &
                     ((selA == FWD_MEM) | (selB == FWD_MEM) | (selC == FWD_MEM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            StIdle: begin
                if (!loadUse && idLive && ID_multicycle) begin
                    stateD = StBusy;
                    cntD   = CNT_W'(FPU_LAT - 2);
                end
            end
            StBusy: begin
                if (cntQ == '0) begin
                    stateD = StIdle;
                end else begin
                    cntD = cntQ - CNT_W'(1);
                end
            end
            default: begin
                stateD = StIdle;
                cntD   = '0;
            end
        endcase
    end

    always_comb begin
        exHold   = busy;
        stallID  = busy | loadUse;
        bubbleEX = ~busy & loadUse;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exTagQ  <= '0;
            memTagQ <= '0;
            wbTagQ  <= '0;
            fwdAQ   <= FWD_RF;
            fwdBQ   <= FWD_RF;
            fwdCQ   <= FWD_RF;
        end else if (busy) begin
            // EX and its selects freeze; MEM sees a bubble while WB drains.
            memTagQ <= '0;
            wbTagQ  <= memTagQ;
        end else if (loadUse) begin
            exTagQ  <= '0;
            memTagQ <= exTagQ;
            wbTagQ  <= memTagQ;
            fwdAQ   <= FWD_RF;
            fwdBQ   <= FWD_RF;
            fwdCQ   <= FWD_RF;
        end else begin
            exTagQ  <= idEntry;
            memTagQ <= exTagQ;
            wbTagQ  <= memTagQ;
            fwdAQ   <= selA;
            fwdBQ   <= selB;
            fwdCQ   <= selC;
        end
    end

    // WB needs no forwarding (write-through register file); kept for pipeline visibility.
    assign unusedWb = ^wbTagQ;

    assign forwardA = fwdAQ;
    assign forwardB = fwdBQ;
    assign forwardC = fwdCQ;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding distances, x0, load-use,
// multi-cycle FPU hold and asynchronous reset during BUSY.
module tb_forward_hazard_unit;

    localparam int FpuLat = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ID_valid;
    logic [5:0] ID_rs1, ID_rs2, ID_rs3;
    logic       ID_rs1Used, ID_rs2Used, ID_rs3Used;
    logic [5:0] ID_rd;
    logic       ID_regWrite, ID_memRead, ID_multicycle;
    logic       flush;
    logic [1:0] forwardA, forwardB, forwardC;
    logic       stallID, bubbleEX, exHold;

    int nAsserts = 0;
    int nFails   = 0;

    forward_hazard_unit #(
        .FPU_LAT(FpuLat),
        .CNT_W  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ID_valid     (ID_valid),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_rs3       (ID_rs3),
        .ID_rs1Used   (ID_rs1Used),
        .ID_rs2Used   (ID_rs2Used),
        .ID_rs3Used   (ID_rs3Used),
        .ID_rd        (ID_rd),
        .ID_regWrite  (ID_regWrite),
        .ID_memRead   (ID_memRead),
        .ID_multicycle(ID_multicycle),
        .flush        (flush),
        .forwardA     (forwardA),
        .forwardB     (forwardB),
        .forwardC     (forwardC),
        .stallID      (stallID),
        .bubbleEX     (bubbleEX),
        .exHold       (exHold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        ID_valid = 0; ID_rd = 0; ID_regWrite = 0; ID_memRead = 0; ID_multicycle = 0;
        ID_rs1 = 0; ID_rs2 = 0; ID_rs3 = 0;
        ID_rs1Used = 0; ID_rs2Used = 0; ID_rs3Used = 0;
        flush = 0;
    endtask

    task automatic issue(input logic [5:0] rd, input logic rw, input logic mr, input logic mc,
                         input logic [5:0] r1, input logic u1, input logic [5:0] r2,
                         input logic u2, input logic [5:0] r3, input logic u3);
        ID_valid = 1; ID_rd = rd; ID_regWrite = rw; ID_memRead = mr; ID_multicycle = mc;
        ID_rs1 = r1; ID_rs2 = r2; ID_rs3 = r3;
        ID_rs1Used = u1; ID_rs2Used = u2; ID_rs3Used = u3;
        flush = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_fwdA", 32'(forwardA), 0);
        check("rst_fwdB", 32'(forwardB), 0);
        check("rst_fwdC", 32'(forwardC), 0);
        check("rst_stall", 32'(stallID), 0);
        check("rst_bubble", 32'(bubbleEX), 0);
        check("rst_hold", 32'(exHold), 0);
        reset = 0;

        // add x5 ; sub uses x5 (rs2 = x5 but not read)
        issue(6'd5, 1, 0, 0, 6'd1, 1, 6'd2, 1, 6'd0, 0);
        cyc();
        issue(6'd10, 1, 0, 0, 6'd5, 1, 6'd5, 0, 6'd0, 0);
        #1 check("b2b_nostall", 32'(stallID), 0);
        cyc();
        check("b2b_fwdA", 32'(forwardA), 2);
        check("unused_fwdB", 32'(forwardB), 0);

        // one instruction in between
        issue(6'd5, 1, 0, 0, 6'd1, 1, 6'd2, 1, 6'd0, 0);
        cyc();
        issue(6'd9, 1, 0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd11, 1, 0, 0, 6'd5, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        check("gap1_fwdA", 32'(forwardA), 1);

        // two in between
        issue(6'd5, 1, 0, 0, 6'd1, 1, 6'd2, 1, 6'd0, 0);
        cyc();
        issue(6'd9, 1, 0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd12, 1, 0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd13, 1, 0, 0, 6'd5, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        check("gap2_fwdA", 32'(forwardA), 0);

        // double producer of x5: newest wins
        issue(6'd5, 1, 0, 0, 6'd1, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd5, 1, 0, 0, 6'd2, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd14, 1, 0, 0, 6'd6, 1, 6'd5, 1, 6'd0, 0);
        cyc();
        check("dbl_fwdB", 32'(forwardB), 2);
        check("dbl_fwdA", 32'(forwardA), 0);

        // load to x0 then read x0 everywhere: no stall, no forwarding
        issue(6'd0, 1, 1, 0, 6'd1, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd15, 1, 0, 0, 6'd0, 1, 6'd0, 1, 6'd0, 1);
        #1 check("x0_nostall", 32'(stallID), 0);
        cyc();
        check("x0_fwdA", 32'(forwardA), 0);
        check("x0_fwdB", 32'(forwardB), 0);
        check("x0_fwdC", 32'(forwardC), 0);

        // load-use on rs2 = x7
        issue(6'd7, 1, 1, 0, 6'd1, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd16, 1, 0, 0, 6'd3, 1, 6'd7, 1, 6'd0, 0);
        #1;
        check("lu_stall", 32'(stallID), 1);
        check("lu_bubble", 32'(bubbleEX), 1);
        check("lu_hold", 32'(exHold), 0);
        cyc();
        check("lu_stall_once", 32'(stallID), 0);
        check("lu_bubble_once", 32'(bubbleEX), 0);
        cyc();
        check("lu_fwdB", 32'(forwardB), 1);

        // flushed producer must not be forwarded
        issue(6'd8, 1, 0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
        flush = 1;
        cyc();
        issue(6'd17, 1, 0, 0, 6'd8, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        check("flush_fwdA", 32'(forwardA), 0);

        // fdiv f1 then fmadd with rs3 = f1
        issue(6'h21, 1, 0, 1, 6'h22, 1, 6'h23, 1, 6'd0, 0);
        #1 check("fdiv_id_hold", 32'(exHold), 0);
        cyc();
        issue(6'h24, 1, 0, 0, 6'h25, 1, 6'h26, 1, 6'h21, 1);
        for (int i = 0; i < FpuLat - 1; i++) begin
            check($sformatf("fdiv_hold_%0d", i), 32'(exHold), 1);
            check($sformatf("fdiv_stall_%0d", i), 32'(stallID), 1);
            check($sformatf("fdiv_bubble_%0d", i), 32'(bubbleEX), 0);
            cyc();
        end
        check("fdiv_release_hold", 32'(exHold), 0);
        check("fdiv_release_stall", 32'(stallID), 0);
        cyc();
        check("fmadd_fwdC", 32'(forwardC), 2);
        check("fmadd_fwdA", 32'(forwardA), 0);

        // async reset in BUSY cycle 3 with a live forward select
        issue(6'h22, 1, 0, 0, 6'd1, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'h21, 1, 0, 1, 6'h22, 1, 6'h23, 1, 6'd0, 0);
        cyc();
        check("busy1_fwdA", 32'(forwardA), 2);
        check("busy1_hold", 32'(exHold), 1);
        nop();
        cyc();
        cyc();
        check("busy3_fwdA_held", 32'(forwardA), 2);
        reset = 1;
        #1;
        check("arst_fwdA", 32'(forwardA), 0);
        check("arst_hold", 32'(exHold), 0);
        check("arst_stall", 32'(stallID), 0);
        check("arst_bubble", 32'(bubbleEX), 0);
        #1 reset = 0;

        // stale fdiv tag must be gone after reset
        issue(6'd18, 1, 0, 0, 6'h21, 1, 6'h22, 1, 6'd0, 0);
        #1 check("post_rst_hold", 32'(exHold), 0);
        cyc();
        check("post_rst_fwdA", 32'(forwardA), 0);
        check("post_rst_fwdB", 32'(forwardB), 0);
        issue(6'd5, 1, 0, 0, 6'd1, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        issue(6'd19, 1, 0, 0, 6'd5, 1, 6'd0, 0, 6'd0, 0);
        cyc();
        check("post_rst_b2b_fwdA", 32'(forwardA), 2);
        nop();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Generates the EX-stage operand-forwarding selects (`forwardA`, `forwardB`, `forwardC`) consumed by the EX operand muxes. It also generates the pipeline stall and bubble controls for load-use hazards and multi-cycle FPU operations. It sits at the ID/EX boundary and keeps its own shadow copy of destination tags for the EX, MEM and WB stages. Selects are registered, so they are valid for the whole EX cycle of the instruction they belong to.

## Interface
Parameters:
- `FPU_LAT`, 8: total EX cycles occupied by a multi-cycle FPU op (fdiv/fsqrt), ≥2.
- `CNT_W`, 4: width of the busy counter; must hold `FPU_LAT-1`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ID_valid`  in  1  ID holds a real instruction.
- `ID_rs1`, `ID_rs2`, `ID_rs3`  in  6 each  source tags {isFloat, index[4:0]}.
- `ID_rs1Used`, `ID_rs2Used`, `ID_rs3Used`  in  1 each  source is actually read.
- `ID_rd`  in  6  destination tag.
- `ID_regWrite`  in  1  instruction writes `ID_rd`.
- `ID_memRead`  in  1  instruction is a load.
- `ID_multicycle`  in  1  instruction is a multi-cycle FPU op.
- `flush`  in  1  branch redirect; kills the ID instruction.
- `forwardA`, `forwardB`, `forwardC`  out  2 each  registered selects: 0 = register file, 1 = WB data (`dataD`), 2 = MEM ALU result. 3 is never driven.
- `stallID`  out  1  hold PC and IF/ID.
- `bubbleEX`  out  1  insert a NOP into ID/EX this cycle.
- `exHold`  out  1  freeze ID/EX; MEM receives a bubble.

## Operation
- Tags: x0 (`6'b0_00000`) never matches and is never forwarded. f0 (`6'b1_00000`) is a real register.
- Shadow stages `exTag`, `memTag`, `wbTag`: each holds {valid, regWrite, memRead, tag}.
  - When the pipeline advances, ID→EX→MEM→WB.
  - When `bubbleEX` is set, EX gets an invalid entry.
  - When `exHold` is set, EX and ID freeze, EX→MEM gets an invalid entry, and MEM→WB still advances.
- Select computation, registered at the advance edge for the instruction entering EX:
  - The producer currently in `exTag` will be in MEM → select 2.
  - The producer in `memTag` will be in WB → select 1.
  - If both match, the newer one wins (2).
  - The register file is write-through, so a producer in `wbTag` needs no forwarding.
  - A source whose `*Used` bit is 0 → 0.
- Load-use: an ID source matches a valid `exTag` with memRead → `stallID`=1 and `bubbleEX`=1 for exactly 1 cycle. On the next cycle the load is in MEM and is covered by select 1.
- Multi-cycle FSM, states IDLE and BUSY:
  - IDLE→BUSY when the op enters EX; the counter loads `FPU_LAT-2`.
  - In BUSY, `exHold`=`stallID`=1 and the counter decrements.
  - BUSY→IDLE after the cycle in which the counter = 0. The FPU latches its operands in the first EX cycle.
- `flush`: the ID instruction enters EX as invalid. It has no effect on BUSY.
- Simultaneous load-use and BUSY: BUSY dominates, and `bubbleEX` stays 0 while `exHold`=1.

## Timing
- Reset (async):
  - all shadow entries invalid;
  - FSM IDLE, counter 0;
  - `forwardA`/`forwardB`/`forwardC`=0;
  - `stallID`=`bubbleEX`=`exHold`=0.
- `stallID`, `bubbleEX` and `exHold` are combinational from the current state and the ID inputs.
- Forward selects have latency 1: computed from ID in cycle n, presented in cycle n+1 (EX). They hold their value while `exHold`=1.
- A multi-cycle op occupies EX for exactly `FPU_LAT` cycles, and `exHold` is high for `FPU_LAT-1` of them.
- Reset mid-BUSY: the next cycle is IDLE with all outputs 0.

## Structure
- Shared package/include holds:
  - the select encodings `FWD_RF`=0, `FWD_WB`=1, `FWD_MEM`=2;
  - the tag width 6;
  - `TAG_X0`;
  - the FSM state encodings.
- One natural sub-module, `fwd_tag_match`: a combinational 6-bit compare of source vs. `exTag`/`memTag` with x0 suppression, producing a 2-bit select. It is instantiated 3× (rs1, rs2, rs3).

## Test plan
- Back-to-back ALU ops: `add x5` then `sub` using x5 as rs1 → `forwardA`=2 in the sub's EX cycle. One instruction in between → 1. Two in between → 0.
- Double producer: `x5` written in consecutive instructions, then read → `forwardB`=2 (newest wins).
- x0 destination then read of x0 → all selects 0 and no stall.
- Load-use: `lw x7` then `add` reading rs2=x7 → one cycle of `stallID`=`bubbleEX`=1, then `forwardB`=1.
- fdiv (`FPU_LAT`=8) followed by `fmadd` with rs3 = fdiv dest:
  - `exHold` is high for 7 cycles;
  - `fmadd` enters EX with `forwardC`=2.
- Async `reset` asserted during BUSY cycle 3 → outputs 0 immediately. After release, a plain ALU stream gets correct selects.
